// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: digit count, blank pattern and the active-low
// hex glyph table ordered {a,b,c,d,e,f,g,dp}.
package seg_pkg;

  localparam int SEG_DIGITS = 8;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  typedef logic [2:0] seg_dig_t;

  // Index is the nibble value; dp (bit 0) is always off.
  localparam logic [7:0] SEG_HEX [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
  };

endpackage

// File: rtl/seg_scan_driver_if.sv
// Display word in, multiplexed digit-enable / segment lines out.
interface seg_scan_driver_if;
  import seg_pkg::*;

  logic [4*SEG_DIGITS-1:0] display;
  logic                    enable;
  logic [SEG_DIGITS-1:0]   led_en;
  logic [7:0]              led_cx;

  modport master (output display, output enable, input led_en, input led_cx);
  modport slave  (input display, input enable, output led_en, output led_cx);

endinterface

// File: rtl/seg_hex_decoder.sv
// Combinational nibble to active-low seven-segment glyph decoder.
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] pattern
);

  always_comb begin
    pattern = SEG_HEX[nibble];
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Eight-digit time-multiplexed seven-segment scanner with registered active-low outputs.
// Optional per-slot enable blanking is compiled in with SEG_DEADTIME_EN.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int SCAN_DIV    = 200000,
  parameter int DEAD_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst,
  seg_scan_driver_if.slave    bus
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [31:0] DEAD_LIM = 32'(DEAD_CYCLES);

`ifdef SEG_DEADTIME_EN
  localparam bit DEADTIME = 1'b1;
`else
  localparam bit DEADTIME = 1'b0;
`endif

  logic [CNT_W-1:0]      div_cnt_reg, div_cnt_next;
  seg_dig_t              dig_reg, dig_next;
  logic [SEG_DIGITS-1:0] led_en_reg, led_en_next;
  logic [7:0]            led_cx_reg, led_cx_next;

  logic [SEG_DIGITS-1:0] dig_onehot;
  logic [3:0]            nibbles [SEG_DIGITS];
  logic [3:0]            nibble;
  logic [7:0]            pattern;
  logic                  in_dead;

  genvar gi;
  generate
    for (gi = 0; gi < SEG_DIGITS; gi++) begin : g_digit
      assign dig_onehot[gi] = (dig_reg == seg_dig_t'(gi));
      assign nibbles[gi]    = bus.display[4*gi +: 4];
    end
  endgenerate

  // The display word is sampled live, so an edit shows on the lit digit next cycle.
  assign nibble = nibbles[dig_reg];

  seg_hex_decoder u_dec (
    .nibble  (nibble),
    .pattern (pattern)
  );

  assign in_dead = DEADTIME && (32'(div_cnt_reg) < DEAD_LIM);

  always_comb begin
    div_cnt_next = '0;
    dig_next     = '0;
    led_en_next  = SEG_OFF;
    led_cx_next  = SEG_OFF;
    if (bus.enable) begin
      if (div_cnt_reg == DIV_LAST) begin
        div_cnt_next = '0;
        dig_next     = seg_dig_t'(dig_reg + 3'd1);
      end else begin
        div_cnt_next = div_cnt_reg + 1'b1;
        dig_next     = dig_reg;
      end
      // Enable and glyph come from the same digit index, so they switch together.
      led_en_next = in_dead ? SEG_OFF : ~dig_onehot;
      led_cx_next = pattern;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_reg <= '0;
      dig_reg     <= '0;
      led_en_reg  <= SEG_OFF;
      led_cx_reg  <= SEG_OFF;
    end else begin
      div_cnt_reg <= div_cnt_next;
      dig_reg     <= dig_next;
      led_en_reg  <= led_en_next;
      led_cx_reg  <= led_cx_next;
    end
  end

  assign bus.led_en = led_en_reg;
  assign bus.led_cx = led_cx_reg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized bench for seg_scan_driver against a slot-arithmetic reference model.
module tb_seg_scan_driver;

  localparam int SCAN_DIV    = 4;
  localparam int DEAD_CYCLES = 1;
`ifdef SEG_DEADTIME_EN
  localparam bit DEAD_ON = 1'b1;
`else
  localparam bit DEAD_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seg_scan_driver_if bus ();

  seg_scan_driver #(
    .SCAN_DIV    (SCAN_DIV),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] hex_tab [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
  };

  int errors = 0;
  int checks = 0;
  bit check_on = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: n_run counts enabled edges since the scan (re)started; digit and
  // phase within the slot follow directly from it.
  int unsigned n_run;
  int          shown_dig;
  logic [7:0]  exp_en, exp_cx;

  function automatic int slot_dig(input int unsigned n);
    return int'((n / SCAN_DIV) % 8);
  endfunction

  function automatic int slot_phase(input int unsigned n);
    return int'(n % SCAN_DIV);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n_run     <= 0;
      shown_dig <= -1;
      exp_en    <= 8'hFF;
      exp_cx    <= 8'hFF;
    end else if (!bus.enable) begin
      n_run     <= 0;
      shown_dig <= -1;
      exp_en    <= 8'hFF;
      exp_cx    <= 8'hFF;
    end else begin
      exp_cx    <= hex_tab[bus.display[4*slot_dig(n_run) +: 4]];
      exp_en    <= (DEAD_ON && slot_phase(n_run) < DEAD_CYCLES) ? 8'hFF : ~(8'h01 << slot_dig(n_run));
      shown_dig <= slot_dig(n_run);
      n_run     <= (n_run + 1) % (8 * SCAN_DIV);
    end
  end

  always @(negedge clk) begin
    if (check_on) begin
      check_val("mon_en", {24'h0, bus.led_en}, {24'h0, exp_en});
      check_val("mon_cx", {24'h0, bus.led_cx}, {24'h0, exp_cx});
    end
  end

  logic [7:0] frame_en [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  logic [7:0] frame_cx [8] = '{8'h09, 8'h03, 8'h71, 8'h03, 8'h25, 8'h9F, 8'h01, 8'h41};

  initial begin
    bus.enable  = 1'b1;
    bus.display = 32'h6800_0000;
    #1 rst = 1'b1;
    check_on = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_en", {24'h0, bus.led_en}, 32'hFF);
    check_val("rst_cx", {24'h0, bus.led_cx}, 32'hFF);
    rst = 1'b0;
    @(negedge clk);
    check_val("first_en", {24'h0, bus.led_en}, DEAD_ON ? 32'hFF : 32'hFE);
    check_val("first_cx", {24'h0, bus.led_cx}, 32'h03);

    // Directed frame from a fresh start, plus the wrap back to DK0.
    bus.enable  = 1'b0;
    bus.display = 32'h6812_0F09;
    @(negedge clk);
    bus.enable = 1'b1;
    for (int k = 0; k < 8 * SCAN_DIV + 1; k++) begin
      @(negedge clk);
      check_val("frame_en", {24'h0, bus.led_en},
                {24'h0, (DEAD_ON && (k % SCAN_DIV) < DEAD_CYCLES) ? 8'hFF : frame_en[(k / SCAN_DIV) % 8]});
      check_val("frame_cx", {24'h0, bus.led_cx}, {24'h0, frame_cx[(k / SCAN_DIV) % 8]});
    end

    // Drop enable mid DK3, then restart.
    for (int i = 0; i < 100 && shown_dig != 3; i++) @(negedge clk);
    check_val("dk3_wait", 32'(shown_dig), 32'd3);
    @(negedge clk);
    bus.enable = 1'b0;
    @(negedge clk);
    check_val("drop_en", {24'h0, bus.led_en}, 32'hFF);
    check_val("drop_cx", {24'h0, bus.led_cx}, 32'hFF);
    bus.enable = 1'b1;
    repeat (SCAN_DIV + 1) @(negedge clk);

    // Live display edit on the lit DK0.
    bus.enable  = 1'b0;
    bus.display = 32'h6812_0F00;
    @(negedge clk);
    bus.enable = 1'b1;
    @(negedge clk);
    check_val("live_cx0", {24'h0, bus.led_cx}, 32'h03);
    bus.display[3:0] = 4'hA;
    @(negedge clk);
    check_val("live_cx1", {24'h0, bus.led_cx}, 32'h11);
    check_val("live_en1", {24'h0, bus.led_en}, 32'hFE);

    // Random display traffic with occasional enable toggles.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) bus.display = $urandom;
      if ($urandom_range(0, 39) == 0) bus.enable = ~bus.enable;
    end
    bus.enable = 1'b1;

    // Asynchronous reset between edges during DK5.
    for (int i = 0; i < 100 && shown_dig != 5; i++) @(negedge clk);
    check_val("dk5_wait", 32'(shown_dig), 32'd5);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("arst_en", {24'h0, bus.led_en}, 32'hFF);
    check_val("arst_cx", {24'h0, bus.led_cx}, 32'hFF);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.display = 32'h0000_0007;
    @(negedge clk);
    check_val("restart_cx", {24'h0, bus.led_cx}, 32'h1F);
    repeat (2 * 8 * SCAN_DIV) @(negedge clk);

    check_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed driver for the board's eight-digit common-anode seven-segment display. Consumes the packed 32-bit, eight-nibble display word assembled by the lab top level and produces registered, active-low digit-enable and segment outputs. It scans one digit per slot and decodes each nibble as hexadecimal 0–F. It is the final stage between the counter datapath and the display pins.

## Interface
Parameters:
- `SCAN_DIV`, default 200000: clock cycles per digit slot (2 ms at 100 MHz). Must be ≥ 2.
- `DEAD_CYCLES`, default 1000: blanking cycles at the start of each slot. Only used with `SEG_DEADTIME_EN`. Must be < `SCAN_DIV`.

Ports:
- `clk`, input, 1: system clock. One clock domain.
- `rst`, input, 1: asynchronous, active-high reset.
- `display`, input, 32: nibble i (`display[4i+3:4i]`) is shown on digit DK i.
- `enable`, input, 1: 1 = scan active; 0 = display dark.
- `led_en`, output, 8: digit enables, active-low. Bit i drives DK i.
- `led_cx`, output, 8: segments, active-low, ordered {a,b,c,d,e,f,g,dp}. Bit 7 = a, bit 0 = dp.

## Operation
- Prescaler `div_cnt` counts 0..`SCAN_DIV`-1 and wraps.
- Digit index `dig` (3 bits) increments when `div_cnt` = `SCAN_DIV`-1. It wraps 7→0.
- Active slot: `led_en` = ~(8'b1 << `dig`). `led_cx` = hex pattern of nibble `dig`.
- dp is always off (bit 0 = 1).
- Hex patterns: 0 = 8'h03, 1 = 8'h9F, 2 = 8'h25, 3 = 8'h0D, 4 = 8'h99, 5 = 8'h49, 6 = 8'h41, 7 = 8'h1F, 8 = 8'h01, 9 = 8'h09, A = 8'h11, b = 8'hC1, C = 8'h63, d = 8'h85, E = 8'h61, F = 8'h71.
- `enable` = 0:
  - `div_cnt` and `dig` are held at 0.
  - `led_en` = 8'hFF and `led_cx` = 8'hFF.
- `enable` 0→1: scanning starts at DK0 with a full slot.
- `enable` 1→0 mid-slot: the display goes dark on the next edge and the counters clear.
- `display` is not latched. A change is reflected on the currently lit digit in the next cycle. No tearing protection is provided.

## Timing
- Reset: `div_cnt` = 0, `dig` = 0, `led_en` = 8'hFF, `led_cx` = 8'hFF.
- Reset asserted mid-scan blanks the outputs immediately (asynchronous). Scanning resumes at DK0 on the first edge after release with `enable` = 1.
- Both outputs are registered.
- Latency: `enable` or `display` change → output change on the following rising edge (1 cycle).
- A digit change appears on `led_en` and `led_cx` in the same cycle. The segments never lead or lag their enable.
- Frame period: 8×`SCAN_DIV` cycles (16 ms by default, ≈62.5 Hz).

## Configuration
- Macro `SEG_DEADTIME_EN` defined:
  - During the first `DEAD_CYCLES` cycles of every slot (`div_cnt` < `DEAD_CYCLES`), `led_en` = 8'hFF.
  - `led_cx` still shows the new digit's pattern during that window.
  - This suppresses ghosting.
- Macro undefined:
  - Each digit is lit for its entire slot.
  - `DEAD_CYCLES` is ignored.

## Structure
- Shared package `seg_pkg`:
  - `SEG_DIGITS` = 8.
  - `SEG_OFF` = 8'hFF.
  - The 16-entry hex pattern constants listed under Operation.
- Sub-module `seg_hex_decoder`: combinational 4-bit → 8-bit active-low decoder. It is reused by later display blocks.
- The top level instantiates `seg_scan_driver` in place of the existing display controller. Port mapping is one-to-one.

## Test plan
All scenarios use `SCAN_DIV` = 4 and `DEAD_CYCLES` = 1.
- Reset held, then released with `enable` = 1 and `display` = 32'h6800_0000 → during reset, outputs are FF/FF. First slot after release: `led_en` = 8'hFE, `led_cx` = 8'h03.
- Run a full frame with `display` = 32'h6812_0F09 (macro off). Each digit must be lit for exactly 4 cycles with its enable and pattern:
  - DK0: 8'hFE / 8'h09
  - DK1: 8'hFD / 8'h03
  - DK2: 8'hFB / 8'h71
  - DK3: 8'hF7 / 8'h03
  - DK4: 8'hEF / 8'h25
  - DK5: 8'hDF / 8'h9F
  - DK6: 8'hBF / 8'h01
  - DK7: 8'h7F / 8'h41
  - After DK7, the scan wraps to DK0.
- Drop `enable` mid-slot at DK3 → the next cycle shows FF/FF. Re-raise `enable` → DK0 is lit on the next edge for a full 4 cycles.
- Change `display[3:0]` from 4'h0 to 4'hA while DK0 is lit → `led_cx` goes 8'h03 → 8'h11 one cycle later. `led_en` is unchanged.
- With `SEG_DEADTIME_EN`: in each slot, `led_en` is FF for 1 cycle, then active-low for 3 cycles. `led_cx` already holds the new pattern during the dark cycle.
- Assert async `rst` mid-cycle (not on an edge) during DK5 → outputs are FF/FF before the next clock edge. Scanning restarts at DK0 after release.
